// File: rtl/gcn_pkg.sv
// Shared defaults, FSM state encoding and width helper for the GCN matmul controller.
// Latency: n/a (package).
// Backpressure: n/a (package).
package gcn_pkg;

   localparam int ROWS_DEF   = 6;
   localparam int INNER_DEF  = 96;
   localparam int COLS_DEF   = 3;
   localparam int DATA_W_DEF = 6;
   localparam int ACC_W_DEF  = 16;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      RUN   = 3'd1,
      FLUSH = 3'd2,
      OUT   = 3'd3,
      DONE  = 3'd4
   } gcnState_t;

   // Address width that never collapses to zero bits for degenerate sizes.
   function automatic int clogb(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/gcn_matmul_ctrl_if.sv
// Control, memory-read and result-row bundle of the GCN matmul controller.
// Latency: n/a (wiring only).
// Backpressure: res_ready from the consumer stalls the result row.
// Ports: master = controller (drives strobes, addresses, results, busy/done);
//        slave  = environment (drives start, read data, res_ready).
interface gcn_matmul_ctrl_if
   import gcn_pkg::*;
#(
   parameter int ROWS   = ROWS_DEF,
   parameter int INNER  = INNER_DEF,
   parameter int COLS   = COLS_DEF,
   parameter int DATA_W = DATA_W_DEF,
   parameter int ACC_W  = ACC_W_DEF
);
   localparam int FA_W = clogb(ROWS * INNER);
   localparam int WA_W = clogb(INNER);
   localparam int RW   = clogb(ROWS);

   logic                     start;
   logic                     busy;
   logic                     done;
   logic                     feat_rd_en;
   logic [FA_W-1:0]          feat_addr;
   logic [DATA_W-1:0]        feat_rd_data;
   logic                     wgt_rd_en;
   logic [WA_W-1:0]          wgt_addr;
   logic [COLS*DATA_W-1:0]   wgt_rd_data;
   logic                     res_valid;
   logic                     res_ready;
   logic [RW-1:0]            res_row;
   logic [COLS*ACC_W-1:0]    res_data;

   modport master (
      input  start, feat_rd_data, wgt_rd_data, res_ready,
      output busy, done, feat_rd_en, feat_addr, wgt_rd_en, wgt_addr,
             res_valid, res_row, res_data
   );

   modport slave (
      output start, feat_rd_data, wgt_rd_data, res_ready,
      input  busy, done, feat_rd_en, feat_addr, wgt_rd_en, wgt_addr,
             res_valid, res_row, res_data
   );

endinterface

// File: rtl/gcn_mac_lane.sv
// Unsigned multiply-accumulate lane with synchronous clear and enable; wraps mod 2^ACC_W.
// Latency: one cycle from en to updated acc.
// Backpressure: none; the caller gates en.
// Ports: clk/rst, clr (zero acc, wins over en), en, a/b operands, acc result.
module gcn_mac_lane
   import gcn_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ACC_W  = ACC_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clr,
   input  logic              en,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   output logic [ACC_W-1:0]  acc
);

   logic [2*DATA_W-1:0] prod;

   assign prod = a * b;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc <= '0;
      end else if (clr) begin
         acc <= '0;
      end else if (en) begin
         acc <= acc + ACC_W'(prod);
      end
   end

endmodule

// File: rtl/gcn_matmul_ctrl.sv
// Sequencer for C = A x B, one result row at a time, using COLS parallel MAC lanes.
// Latency: 98 cycles start->row 0 valid, 98 per further row, done 589 cycles after start (defaults).
// Backpressure: res_ready low holds the row in OUT with no reads issued.
// Ports: clk, rst (async, active-high); bus = start/busy/done, feature+weight read ports, result row.
module gcn_matmul_ctrl
   import gcn_pkg::*;
#(
   parameter int ROWS   = ROWS_DEF,
   parameter int INNER  = INNER_DEF,
   parameter int COLS   = COLS_DEF,
   parameter int DATA_W = DATA_W_DEF,
   parameter int ACC_W  = ACC_W_DEF
) (
   input  logic               clk,
   input  logic               rst,
   gcn_matmul_ctrl_if.master  bus
);

   localparam int FA_W = clogb(ROWS * INNER);
   localparam int WA_W = clogb(INNER);
   localparam int RW   = clogb(ROWS);

   gcnState_t             state, nextState;
   logic [RW-1:0]         rowIdx;
   logic [WA_W-1:0]       colIdx;
   logic                  rdEn;
   logic                  rdVld;
   logic                  clrAcc;
   logic                  rowInc;
   logic                  rowClr;
   logic [COLS*ACC_W-1:0] accBus;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= nextState;
      end
   end

   always_comb begin
      nextState = state;
      clrAcc    = 1'b0;
      rowInc    = 1'b0;
      rowClr    = 1'b0;
      case (state)
         IDLE: begin
            if (bus.start) begin
               nextState = RUN;
               clrAcc    = 1'b1;
               rowClr    = 1'b1;
            end
         end
         RUN: begin
            if (colIdx == WA_W'(INNER - 1)) begin
               nextState = FLUSH;
            end
         end
         // Last read's data lands this cycle; the lanes absorb it before OUT.
         FLUSH: nextState = OUT;
         OUT: begin
            if (bus.res_ready) begin
               if (rowIdx == RW'(ROWS - 1)) begin
                  nextState = DONE;
               end else begin
                  nextState = RUN;
                  rowInc    = 1'b1;
                  clrAcc    = 1'b1;
               end
            end
         end
         DONE:    nextState = IDLE;
         default: nextState = IDLE;
      endcase
   end

   assign rdEn = (state == RUN);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rowIdx <= '0;
         colIdx <= '0;
         rdVld  <= 1'b0;
      end else begin
         rdVld <= rdEn;
         if (rowClr) begin
            rowIdx <= '0;
         end else if (rowInc) begin
            rowIdx <= rowIdx + 1'b1;
         end
         // Column counter only advances while reading and self-clears on the last column.
         colIdx <= (rdEn && (colIdx != WA_W'(INNER - 1))) ? colIdx + 1'b1 : '0;
      end
   end

   assign bus.feat_rd_en = rdEn;
   assign bus.wgt_rd_en  = rdEn;
   assign bus.feat_addr  = rdEn ? (FA_W'(rowIdx) * FA_W'(INNER) + FA_W'(colIdx)) : '0;
   assign bus.wgt_addr   = rdEn ? colIdx : '0;

   for (genvar k = 0; k < COLS; k++) begin : gLane
      gcn_mac_lane #(
         .DATA_W (DATA_W),
         .ACC_W  (ACC_W)
      ) uLane (
         .clk (clk),
         .rst (rst),
         .clr (clrAcc),
         .en  (rdVld),
         .a   (bus.feat_rd_data),
         .b   (bus.wgt_rd_data[k*DATA_W +: DATA_W]),
         .acc (accBus[k*ACC_W +: ACC_W])
      );
   end

   assign bus.busy      = (state != IDLE);
   assign bus.done      = (state == DONE);
   assign bus.res_valid = (state == OUT);
   assign bus.res_row   = rowIdx;
   assign bus.res_data  = accBus;

endmodule

// File: tb/tb_gcn_matmul_ctrl.sv
module tb_gcn_matmul_ctrl;
   import gcn_pkg::*;

   localparam int ROWS   = 6;
   localparam int INNER  = 96;
   localparam int COLS   = 3;
   localparam int DATA_W = 6;
   localparam int ACC_W  = 16;
   localparam int FA_W   = clogb(ROWS * INNER);
   localparam int WA_W   = clogb(INNER);
   localparam int RW     = clogb(ROWS);

   typedef struct {
      string name;
      int    pat;        // 0: all ones, 1: all 63, 2: identity A, B=j+k
      int    expConst;   // expected C[i][k] for constant patterns
      int    stallRow;   // row to hold with res_ready low, -1 for none
      int    stallLen;
      int    startPulse; // cycle of a stray start pulse, -1 for none
      int    expDone;    // cycle in which done must be high
   } vec_t;

   logic clk;
   logic rst;
   int   errors;
   int   checks;
   vec_t vecs [5];

   logic [DATA_W-1:0]      featMem [ROWS*INNER];
   logic [COLS*DATA_W-1:0] wgtMem  [INNER];

   gcn_matmul_ctrl_if #(.ROWS(ROWS), .INNER(INNER), .COLS(COLS),
                        .DATA_W(DATA_W), .ACC_W(ACC_W)) bus ();

   gcn_matmul_ctrl #(.ROWS(ROWS), .INNER(INNER), .COLS(COLS),
                     .DATA_W(DATA_W), .ACC_W(ACC_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Synchronous-read memories: data valid the cycle after the strobe.
   always @(posedge clk) begin
      if (bus.feat_rd_en) bus.feat_rd_data <= featMem[bus.feat_addr];
      if (bus.wgt_rd_en)  bus.wgt_rd_data  <= wgtMem[bus.wgt_addr];
   end

   task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, got, exp);
      end
   endtask

   task automatic loadPattern(input int pat);
      for (int i = 0; i < ROWS; i++)
         for (int j = 0; j < INNER; j++)
            featMem[i*INNER+j] = (pat == 0) ? DATA_W'(1) :
                                 (pat == 1) ? DATA_W'(63) : DATA_W'(j == i);
      for (int j = 0; j < INNER; j++)
         for (int k = 0; k < COLS; k++)
            wgtMem[j][k*DATA_W +: DATA_W] = (pat == 0) ? DATA_W'(1) :
                                            (pat == 1) ? DATA_W'(63) : DATA_W'(j + k);
   endtask

   function automatic logic [COLS*ACC_W-1:0] expRowData(input int pat, input int i, input int c);
      logic [COLS*ACC_W-1:0] r;
      r = '0;
      for (int k = 0; k < COLS; k++)
         r[k*ACC_W +: ACC_W] = (pat == 2) ? ACC_W'(i + k) : ACC_W'(c);
      return r;
   endfunction

   task automatic checkAllZero(input string tag);
      check({tag, "_busy"},      64'(bus.busy),       64'(0));
      check({tag, "_done"},      64'(bus.done),       64'(0));
      check({tag, "_res_valid"}, 64'(bus.res_valid),  64'(0));
      check({tag, "_feat_en"},   64'(bus.feat_rd_en), 64'(0));
      check({tag, "_wgt_en"},    64'(bus.wgt_rd_en),  64'(0));
      check({tag, "_feat_addr"}, 64'(bus.feat_addr),  64'(0));
      check({tag, "_wgt_addr"},  64'(bus.wgt_addr),   64'(0));
      check({tag, "_res_row"},   64'(bus.res_row),    64'(0));
      check({tag, "_res_data"},  64'(bus.res_data),   64'(0));
   endtask

   task automatic runVector(input vec_t v);
      int   c, row, doneCnt, doneCyc, strobes, addrErr, stallErr, stallLeft, expJ, expRowRd, post, expFirst;
      logic prevValid;
      logic [COLS*ACC_W-1:0] heldData;
      bit   finished;
      c = 0; row = 0; doneCnt = 0; doneCyc = -1; strobes = 0; addrErr = 0; stallErr = 0;
      stallLeft = 0; expJ = 0; expRowRd = 0; post = 0; prevValid = 1'b0; heldData = '0; finished = 0;
      loadPattern(v.pat);
      @(negedge clk);
      bus.start     = 1'b1;   // cycle 0: start sampled at the end of this cycle
      bus.res_ready = 1'b1;
      @(negedge clk);
      c = 1;
      while (!finished && c < 1500) begin
         bus.start = (c == v.startPulse);
         if (bus.feat_rd_en !== bus.wgt_rd_en) addrErr++;
         if (bus.feat_rd_en) begin
            strobes++;
            if (bus.feat_addr !== FA_W'(expRowRd*INNER + expJ) || bus.wgt_addr !== WA_W'(expJ))
               addrErr++;
            expJ++;
            if (expJ == INNER) begin
               expJ = 0;
               expRowRd++;
            end
         end
         if (bus.res_valid && !prevValid) begin
            expFirst = 98 + 98*row + ((v.stallRow >= 0 && row > v.stallRow) ? v.stallLen : 0);
            check($sformatf("%s_row%0d_first_valid_cycle", v.name, row), 64'(c), 64'(expFirst));
            heldData = bus.res_data;
            if (int'(bus.res_row) == v.stallRow) stallLeft = v.stallLen;
         end
         if (bus.res_valid && (bus.res_data !== heldData || bus.feat_rd_en)) stallErr++;
         bus.res_ready = (stallLeft == 0);
         if (stallLeft > 0) stallLeft--;
         if (bus.res_valid && bus.res_ready) begin
            check($sformatf("%s_row%0d_index", v.name, row), 64'(bus.res_row), 64'(row));
            check($sformatf("%s_row%0d_data", v.name, row), 64'(bus.res_data),
                  64'(expRowData(v.pat, row, v.expConst)));
            row++;
         end
         if (bus.done) begin
            doneCnt++;
            doneCyc = c;
         end
         if (doneCnt > 0) begin
            post++;
            if (post == 6) finished = 1;
         end
         prevValid = bus.res_valid;
         @(negedge clk);
         c++;
      end
      bus.start     = 1'b0;
      bus.res_ready = 1'b1;
      check({v.name, "_finished"},   64'(finished), 64'(1));
      check({v.name, "_rows"},       64'(row),      64'(ROWS));
      check({v.name, "_strobes"},    64'(strobes),  64'(ROWS*INNER));
      check({v.name, "_addr_seq"},   64'(addrErr),  64'(0));
      check({v.name, "_hold"},       64'(stallErr), 64'(0));
      check({v.name, "_done_count"}, 64'(doneCnt),  64'(1));
      check({v.name, "_done_cycle"}, 64'(doneCyc),  64'(v.expDone));
      check({v.name, "_idle_after"}, 64'(bus.busy), 64'(0));
   endtask

   initial begin
      int c;
      vec_t after;
      errors = 0;
      checks = 0;
      //           name            pat  const   stallRow len pulse done
      vecs[0] = '{"ones",          0,   16'h0060, -1,    0,  -1,  589};
      vecs[1] = '{"max_wrap",      1,   16'hD060, -1,    0,  -1,  589};
      vecs[2] = '{"diag",          2,   0,        -1,    0,  -1,  589};
      vecs[3] = '{"stall_row2",    0,   16'h0060,  2,   10,  -1,  599};
      vecs[4] = '{"start_in_run",  2,   0,        -1,    0,  50,  589};

      rst = 1'b1;
      bus.start = 1'b0;
      bus.res_ready = 1'b0;
      bus.feat_rd_data = '0;
      bus.wgt_rd_data = '0;
      repeat (2) @(negedge clk);
      checkAllZero("por");
      rst = 1'b0;
      @(negedge clk);

      for (int n = 0; n < 5; n++) runVector(vecs[n]);

      // Reset in the middle of row 3, then a clean product must follow.
      loadPattern(0);
      @(negedge clk);
      bus.start = 1'b1;
      bus.res_ready = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      c = 1;
      while (c < 300) begin
         @(negedge clk);
         c++;
      end
      check("mid_busy_before_rst", 64'(bus.busy), 64'(1));
      rst = 1'b1;
      #1;
      checkAllZero("midrst");
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      after = vecs[2];
      after.name = "after_rst";
      runVector(after);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/gcn_matmul_ctrl.md
GCN_MATMUL_CTRL -- requirements
Module: gcn_matmul_ctrl

Interface
REQ-001 Parameter ROWS, default 6: number of feature-matrix rows (A rows, result rows).
REQ-002 Parameter INNER, default 96: inner dimension (A columns, B rows).
REQ-003 Parameter COLS, default 3: number of weight-matrix columns (B columns, result columns).
REQ-004 Parameter DATA_W, default 6: unsigned element width of A and B.
REQ-005 Parameter ACC_W, default 16: unsigned accumulator and result element width.
REQ-006 clk  in  1  single clock; all state changes on its rising edge.
REQ-007 rst  in  1  reset, asynchronous, active-high.
REQ-008 start  in  1  request one full ROWSxCOLS product; sampled only in IDLE.
REQ-009 busy  out  1  high whenever the state is not IDLE.
REQ-010 done  out  1  one-cycle pulse after the last result row is accepted.
REQ-011 feat_rd_en  out  1  feature memory read strobe.
REQ-012 feat_addr  out  clog2(ROWS*INNER)  feature address, value i*INNER+j.
REQ-013 feat_rd_data  in  DATA_W  A[i][j], valid one cycle after the strobe.
REQ-014 wgt_rd_en  out  1  weight memory read strobe, asserted identically to feat_rd_en.
REQ-015 wgt_addr  out  clog2(INNER)  weight row address j.
REQ-016 wgt_rd_data  in  COLS*DATA_W  B[j][0..COLS-1]; column k at bits [k*DATA_W +: DATA_W]; valid one cycle after the strobe.
REQ-017 res_valid  out  1  result row available.
REQ-018 res_ready  in  1  consumer accepts the result row.
REQ-019 res_row  out  clog2(ROWS)  index i of the presented row.
REQ-020 res_data  out  COLS*ACC_W  C[i][k] at bits [k*ACC_W +: ACC_W].

Function
REQ-021 The FSM SHALL have the states IDLE, RUN, FLUSH, OUT and DONE.
REQ-022 In IDLE with start=1: row index i SHALL be set to 0, all accumulators SHALL be cleared, and the FSM SHALL go to RUN.
REQ-023 RUN SHALL issue exactly one read per cycle for j=0..INNER-1 in order, then go to FLUSH after j=INNER-1.
REQ-024 The read-data-valid flag SHALL be a one-cycle-delayed copy of feat_rd_en.
REQ-025 When that flag is high, acc[k] SHALL update to (acc[k] + feat_rd_data*wgt_k) mod 2^ACC_W for every k in parallel.
REQ-026 The product SHALL be unsigned, 2*DATA_W bits, zero-extended before the add; overflow SHALL wrap silently.
REQ-027 FLUSH SHALL last one cycle (the final accumulate) and then go to OUT.
REQ-028 In OUT, res_valid=1 and res_row=i; res_data SHALL hold the accumulators and remain stable until the handshake.
REQ-029 The handshake res_valid&res_ready with i<ROWS-1 SHALL increment i, clear the accumulators and return to RUN.
REQ-030 The handshake with i=ROWS-1 SHALL go to DONE.
REQ-031 DONE SHALL assert done for exactly one cycle and then return to IDLE.
REQ-032 res_ready low SHALL hold OUT indefinitely with no reads issued.
REQ-033 start while not IDLE SHALL be ignored and SHALL NOT be queued.
REQ-034 Read strobes SHALL be 0 outside RUN.
REQ-035 Latency with res_ready held 1: start sampled in cycle 0; row i res_valid first high in cycle 98+98*i; done high in cycle 589.

Reset
REQ-036 Asserting rst SHALL immediately force state IDLE, busy=0, done=0, res_valid=0, feat_rd_en=0, wgt_rd_en=0, all addresses 0, i=0, all accumulators 0 and the valid flag 0.
REQ-037 After reset is released mid-operation, no partial result SHALL be presented, and the next start SHALL begin from row 0.

Structure
REQ-038 Parameter defaults and the state enumeration SHALL live in shared package gcn_pkg.
REQ-039 One sub-module gcn_mac_lane (a multiply-accumulate unit with clear and enable, ACC_W wide) SHALL be instantiated COLS times.

Verification
REQ-040 All A=1 and all B=1, res_ready=1: every row gives C[i][k]=0x0060; done in cycle 589.
REQ-041 All A=63 and all B=63: every C[i][k]=0xD060 (381024 mod 65536, wrap-around).
REQ-042 A[i][j]=(j==i), B[j][k]=j+k: C[i][k]=i+k; res_row takes the values 0..5 in order.
REQ-043 res_ready=0 for 10 cycles on row 2: res_valid and res_data stay stable, no read strobes, and done is delayed by 10 cycles.
REQ-044 start pulsed in RUN: ignored, exactly six rows and one done.
REQ-045 rst asserted in cycle 300, then start again: all outputs immediately at reset values, and a clean six-row result sequence follows.
